gate_truth_sweeper: RTL and testbench
=====================================

Name: gate_truth_sweeper

Overview:
- Sequential stimulus/checker stage that sits directly upstream of a 2-input bitwise gate under test, such as the AND gate.
- On a start pulse it walks every (a, b) operand combination and drives it into the gate.
- After a settle interval it samples the gate output `c` and compares it against a golden result for the selected operation.
- It counts passes and fails and records the first failing vector, which allows self-checking gate benches and on-board gate sanity tests.

Parameters:
- WIDTH, 1, operand width in bits; the sweep covers 2^(2*WIDTH) vectors.
- SETTLE_CYCLES, 2, cycles each vector is held before `c` is sampled; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- op_sel  input  2  golden op: 00 AND, 01 OR, 10 XOR, 11 NAND; latched on start
- a  output  WIDTH  operand A to the gate under test
- b  output  WIDTH  operand B to the gate under test
- c  input  WIDTH  gate-under-test result
- busy  output  1  high from the cycle after start acceptance through the DONE cycle
- done  output  1  one-cycle pulse at sweep end
- pass_count  output  2*WIDTH+1  vectors matching the golden result
- fail_count  output  2*WIDTH+1  vectors mismatching the golden result
- fail_seen  output  1  at least one mismatch in the current/last sweep
- first_fail_idx  output  2*WIDTH  index of the first mismatching vector

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
  - rst=1 at any edge forces IDLE and zeroes all of: a, b, busy, done, pass_count, fail_count, fail_seen, first_fail_idx, the vector index and the settle counter.
  - This holds mid-sweep; there is no partial completion.
- Vector mapping:
  - idx is 2*WIDTH bits; a = idx[WIDTH-1:0], b = idx[2*WIDTH-1:WIDTH].
  - `a` toggles fastest. For WIDTH=1 the order is (a,b) = 00, 10, 01, 11.
- Golden result: exp = a&b, a|b, a^b or ~(a&b), per the latched op.
- FSM states: IDLE, DRIVE, CHECK, DONE.
  - IDLE: a=b=0. If start=1, then at the next edge:
    - idx←0
    - the results registers clear
    - op is latched
    - settle counter←SETTLE_CYCLES-1
    - state←DRIVE
  - DRIVE: a/b hold vector idx for SETTLE_CYCLES cycles. When the counter reaches 0, go to CHECK.
  - CHECK: one cycle.
    - Sample c and compare it with exp.
    - On a match, pass_count+1. On a mismatch, fail_count+1; if fail_seen=0, set fail_seen and capture first_fail_idx←idx.
    - If idx is all-ones, go to DONE. Otherwise idx+1 (no wrap is ever reached), reload the counter and go to DRIVE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Timing: start accepted at edge k → vector v is sampled in the cycle after edge k+SETTLE_CYCLES+v*(SETTLE_CYCLES+1).
  - done is high in the cycle after edge k+2^(2W)*(SETTLE_CYCLES+1).
  - For W=1, S=2, done is high after edge k+12.
- Result registers (pass_count, fail_count, fail_seen, first_fail_idx) hold their values after DONE until the next accepted start.
- Boundary conditions:
  - start while busy: ignored.
  - start held high continuously: a new sweep starts on the first IDLE edge.
  - op_sel changes mid-sweep: no effect.
  - pass_count + fail_count = 2^(2*WIDTH) at done; the counter width guarantees no overflow.
  - Outputs are registered; a/b change only on clock edges.

Decomposition:
- Shared include gate_check_defs.vh holds:
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11
  - FSM state encodings
- Sub-module golden_gate (combinational, WIDTH-parameterised; inputs a, b, op; output exp) is reused by the future OR/XOR gate benches.

Test Plan:
- W=1, S=2, op=AND, correct AND gate connected, start pulse:
  - a,b sequence 00,10,01,11;
  - done after edge k+12;
  - pass=4, fail=0, fail_seen=0.
- W=1, op=OR with an AND gate connected:
  - mismatches at idx 1 and 2;
  - fail=2, pass=2, first_fail_idx=1.
- W=2, S=1, op=XOR, correct XOR gate:
  - 16 vectors;
  - done after edge k+32;
  - pass=16.
- rst asserted during the DRIVE of idx 2:
  - next cycle a=b=0, busy=0, counts=0;
  - a subsequent start runs a clean full sweep.
- start pulsed again while busy and op_sel toggled mid-sweep:
  - no restart;
  - results reflect the op latched at the original start;
  - exactly one done pulse.
- Back-to-back sweeps with start held high:
  - second sweep begins the edge after DONE;
  - results cleared at acceptance.

Source files
------------

// File: rtl/gate_truth_sweeper_pkg.sv
// gate_truth_sweeper_pkg
//   Shared definitions for the gate truth-table sweeper and its golden model:
//   golden operation encodings and the sweep FSM state encoding.
//   No ports; imported by golden_gate and gate_truth_sweeper.
package gate_truth_sweeper_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/gate_truth_sweeper_golden_gate.sv
// golden_gate
//   Combinational reference for a 2-input bitwise gate. Kept as its own block
//   so the OR/XOR gate benches can reuse the same golden model.
//   Ports:
//     a, b  in  WIDTH  operands
//     op    in  2      operation select (AND / OR / XOR / NAND)
//     exp   out WIDTH  expected gate result
module golden_gate
  import gate_truth_sweeper_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] exp
);

  always_comb begin
    exp = '0;
    case (op)
      OP_AND:  exp = a & b;
      OP_OR:   exp = a | b;
      OP_XOR:  exp = a ^ b;
      OP_NAND: exp = ~(a & b);
      default: exp = '0;
    endcase
  end

endmodule

// File: rtl/gate_truth_sweeper.sv
// gate_truth_sweeper
//   Walks every (a, b) operand combination into a 2-input gate under test,
//   holds each vector for SETTLE_CYCLES cycles, samples the gate output c and
//   compares it with the golden result of the operation latched at start.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           begin a sweep (only sampled in IDLE)
//     op_sel          golden operation, latched on start
//     a, b            registered operands to the gate under test
//     c               gate-under-test result
//     busy            high from the cycle after acceptance through DONE
//     done            one-cycle pulse at sweep end
//     pass_count      vectors that matched
//     fail_count      vectors that mismatched
//     fail_seen       at least one mismatch in the current/last sweep
//     first_fail_idx  vector index of the first mismatch
module gate_truth_sweeper
  import gate_truth_sweeper_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op_sel,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     pass_count,
  output logic [2*WIDTH:0]     fail_count,
  output logic                 fail_seen,
  output logic [2*WIDTH-1:0]   first_fail_idx
);

  localparam int IW = 2 * WIDTH;
  // A settle of one cycle still needs a one-bit counter.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_RELOAD = CW'(SETTLE_CYCLES - 1);

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_d;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            busy_q;
  logic            done_q;
  logic [IW:0]     pass_q;
  logic [IW:0]     fail_q;
  logic            fail_seen_q;
  logic [IW-1:0]   first_fail_q;
  logic [WIDTH-1:0] exp_w;
  logic            match_w;

  assign idx_d = idx_q + 1'b1;

  // Golden result is computed from the registered operands, so it lines up
  // with the vector the gate under test is currently seeing.
  golden_gate #(.WIDTH(WIDTH)) u_golden (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .exp (exp_w)
  );

  assign match_w = (c == exp_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= '0;
      fail_q       <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          a_q <= '0;
          b_q <= '0;
          if (start) begin
            idx_q        <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
            op_q         <= op_sel;
            cnt_q        <= SETTLE_RELOAD;
            busy_q       <= 1'b1;
            state_q      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_CHECK: begin
          if (match_w) begin
            pass_q <= pass_q + 1'b1;
          end else begin
            fail_q <= fail_q + 1'b1;
            if (!fail_seen_q) begin
              fail_seen_q  <= 1'b1;
              first_fail_q <= idx_q;
            end
          end
          if (&idx_q) begin
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            // a occupies the low half of idx so it toggles fastest.
            idx_q   <= idx_d;
            a_q     <= idx_d[WIDTH-1:0];
            b_q     <= idx_d[IW-1:WIDTH];
            cnt_q   <= SETTLE_RELOAD;
            state_q <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign fail_seen      = fail_seen_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// tb_gate_truth_sweeper
//   Two sweeper instances (W=1,S=2 and W=2,S=1) each driving a bench-side
//   gate model whose type and an optional single-vector fault are chosen per
//   sweep. Expected cycle-by-cycle operands/handshakes and final results are
//   derived from the truth table of the chosen gate versus the golden op.
module tb_gate_truth_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start2;
  logic [1:0] op1, op2;

  logic [0:0] a1, b1, c1;
  logic       busy1, done1, fs1;
  logic [2:0] pass1, fail1;
  logic [1:0] ffi1;

  logic [1:0] a2, b2, c2;
  logic       busy2, done2, fs2;
  logic [4:0] pass2, fail2;
  logic [3:0] ffi2;

  int checks = 0;
  int failures = 0;

  // Gate-under-test configuration per instance.
  int         gut1 = 0, gut2 = 0;
  bit         fen1 = 0, fen2 = 0;
  logic [3:0] fidx1 = '0, fidx2 = '0;
  logic [1:0] fmask1 = '0, fmask2 = '0;

  function automatic logic [1:0] gate_fn(int kind, logic [1:0] x, logic [1:0] y);
    case (kind)
      0:       return x & y;
      1:       return x | y;
      2:       return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  logic [1:0] g1, g2;
  assign g1 = gate_fn(gut1, {1'b0, a1}, {1'b0, b1});
  assign c1 = g1[0] ^ ((fen1 && {2'b00, b1, a1} == fidx1) ? fmask1[0] : 1'b0);
  assign g2 = gate_fn(gut2, a2, b2);
  assign c2 = g2 ^ ((fen2 && {b2, a2} == fidx2) ? fmask2 : 2'b00);

  gate_truth_sweeper #(.WIDTH(1), .SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sel(op1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
    .pass_count(pass1), .fail_count(fail1), .fail_seen(fs1),
    .first_fail_idx(ffi1)
  );

  gate_truth_sweeper #(.WIDTH(2), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_sel(op2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2),
    .pass_count(pass2), .fail_count(fail2), .fail_seen(fs2),
    .first_fail_idx(ffi2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int id, input logic v);
    if (id == 1) start1 = v; else start2 = v;
  endtask

  task automatic set_op(input int id, input logic [1:0] v);
    if (id == 1) op1 = v; else op2 = v;
  endtask

  task automatic observe(input int id, output logic [31:0] oa, output logic [31:0] ob,
                         output logic [31:0] obusy, output logic [31:0] odone,
                         output logic [31:0] opass, output logic [31:0] ofail,
                         output logic [31:0] ofs, output logic [31:0] offi);
    if (id == 1) begin
      oa = 32'(a1); ob = 32'(b1); obusy = 32'(busy1); odone = 32'(done1);
      opass = 32'(pass1); ofail = 32'(fail1); ofs = 32'(fs1); offi = 32'(ffi1);
    end else begin
      oa = 32'(a2); ob = 32'(b2); obusy = 32'(busy2); odone = 32'(done2);
      opass = 32'(pass2); ofail = 32'(fail2); ofs = 32'(fs2); offi = 32'(ffi2);
    end
  endtask

  task automatic check_results(input int id, input string tag, input int ep, input int ef,
                               input bit efs, input int efi);
    logic [31:0] oa, ob, obusy, odone, opass, ofail, ofs, offi;
    observe(id, oa, ob, obusy, odone, opass, ofail, ofs, offi);
    chk($sformatf("%s_pass", tag), opass, 32'(ep));
    chk($sformatf("%s_fail", tag), ofail, 32'(ef));
    chk($sformatf("%s_fail_seen", tag), ofs, 32'(efs));
    chk($sformatf("%s_first_fail", tag), offi, 32'(efi));
  endtask

  // One full sweep on instance id with per-cycle checking.
  // hold: keep start high so a second sweep is accepted after DONE.
  // misc: re-pulse start and wiggle op_sel mid-sweep.
  task automatic sweep(input int id, input logic [1:0] op, input bit hold, input bit misc);
    int W, S, N, T, gut, fidx, ep, ef, efi, v, dones;
    bit efs, fen, seen;
    logic [1:0] m, x, y, g, e, fmask;
    logic [31:0] oa, ob, obusy, odone, opass, ofail, ofs, offi;
    string tg;
    W = (id == 1) ? 1 : 2;
    S = (id == 1) ? 2 : 1;
    N = 1 << (2 * W);
    T = N * (S + 1);
    m = (id == 1) ? 2'b01 : 2'b11;
    gut = (id == 1) ? gut1 : gut2;
    fen = (id == 1) ? fen1 : fen2;
    fidx = (id == 1) ? int'(fidx1) : int'(fidx2);
    fmask = (id == 1) ? fmask1 : fmask2;
    // Reference: walk the truth table directly.
    ep = 0; ef = 0; efi = 0; efs = 0;
    for (int k = 0; k < N; k++) begin
      x = 2'(k) & m;
      y = 2'(k >> W) & m;
      g = gate_fn(gut, x, y) & m;
      if (fen && k == fidx) g = g ^ (fmask & m);
      e = gate_fn(int'(op), x, y) & m;
      if (g == e) ep++;
      else begin
        ef++;
        if (!efs) begin efs = 1; efi = k; end
      end
    end
    tg = $sformatf("d%0d_op%0d_g%0d", id, op, gut);

    set_start(id, 1'b1);
    set_op(id, op);
    @(posedge clk); #1;
    if (!hold) set_start(id, 1'b0);
    dones = 0;
    for (int t = 0; t <= T + 1; t++) begin
      observe(id, oa, ob, obusy, odone, opass, ofail, ofs, offi);
      if (odone == 1) dones++;
      if (t < T) begin
        v = t / (S + 1);
        chk($sformatf("%s_t%0d_a", tg, t), oa, 32'(v % (1 << W)));
        chk($sformatf("%s_t%0d_b", tg, t), ob, 32'(v >> W));
      end
      chk($sformatf("%s_t%0d_busy", tg, t), obusy, 32'(t <= T));
      chk($sformatf("%s_t%0d_done", tg, t), odone, 32'(t == T));
      if (t == T) check_results(id, tg, ep, ef, efs, efi);
      if (misc && t == 3) begin set_start(id, 1'b1); set_op(id, op ^ 2'b01); end
      if (misc && t == 4) set_start(id, 1'b0);
      if (misc && t == 5) set_op(id, ~op);
      if (t <= T) begin @(posedge clk); #1; end
    end
    check_results(id, {tg, "_hold"}, ep, ef, efs, efi);
    chk($sformatf("%s_done_pulses", tg), 32'(dones), 32'd1);
    chk($sformatf("%s_idle_a", tg), oa, 32'd0);

    if (hold) begin
      @(posedge clk); #1;
      observe(id, oa, ob, obusy, odone, opass, ofail, ofs, offi);
      chk($sformatf("%s_re_busy", tg), obusy, 32'd1);
      chk($sformatf("%s_re_pass_clr", tg), opass, 32'd0);
      chk($sformatf("%s_re_fail_clr", tg), ofail, 32'd0);
      set_start(id, 1'b0);
      seen = 0;
      for (int i = 0; i < 4 * T && !seen; i++) begin
        @(posedge clk); #1;
        observe(id, oa, ob, obusy, odone, opass, ofail, ofs, offi);
        if (odone == 1) seen = 1;
      end
      chk($sformatf("%s_re_done_seen", tg), 32'(seen), 32'd1);
      check_results(id, {tg, "_re"}, ep, ef, efs, efi);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input int id, input string tag);
    logic [31:0] oa, ob, obusy, odone, opass, ofail, ofs, offi;
    observe(id, oa, ob, obusy, odone, opass, ofail, ofs, offi);
    chk({tag, "_a"}, oa, 0);
    chk({tag, "_b"}, ob, 0);
    chk({tag, "_busy"}, obusy, 0);
    chk({tag, "_done"}, odone, 0);
    chk({tag, "_pass"}, opass, 0);
    chk({tag, "_fail"}, ofail, 0);
    chk({tag, "_fail_seen"}, ofs, 0);
    chk({tag, "_first_fail"}, offi, 0);
  endtask

  initial begin
    int id;
    logic [1:0] rop;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; op1 = 2'b00; op2 = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_zero(1, "reset1");
    check_zero(2, "reset2");
    rst = 1'b0;
    @(posedge clk); #1;

    // Correct AND gate, AND golden.
    gut1 = 0;
    sweep(1, 2'b00, 0, 0);
    // AND gate, OR golden: mismatches at idx 1 and 2.
    sweep(1, 2'b01, 0, 0);
    // W=2 correct XOR gate.
    gut2 = 2;
    sweep(2, 2'b10, 0, 0);

    // Reset during DRIVE of idx 2.
    gut1 = 0;
    start1 = 1'b1; op1 = 2'b00;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_b", 32'(b1), 32'd1);
    chk("pre_rst_pass", 32'(pass1), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero(1, "mid_rst");
    gut1 = 3;
    sweep(1, 2'b11, 0, 0);

    // Start re-pulse and op_sel churn mid-sweep.
    gut1 = 0;
    sweep(1, 2'b10, 0, 1);
    gut2 = 1;
    sweep(2, 2'b00, 0, 1);

    // Back-to-back with start held high.
    gut2 = 1;
    sweep(2, 2'b01, 1, 0);

    // Randomized gates, ops and single-vector faults.
    for (int r = 0; r < 8; r++) begin
      id = int'($urandom_range(1, 2));
      rop = 2'($urandom_range(0, 3));
      if (id == 1) begin
        gut1 = int'($urandom_range(0, 3));
        fen1 = 1'($urandom_range(0, 1));
        fidx1 = 4'($urandom_range(0, 3));
        fmask1 = 2'($urandom_range(0, 1));
      end else begin
        gut2 = int'($urandom_range(0, 3));
        fen2 = 1'($urandom_range(0, 1));
        fidx2 = 4'($urandom_range(0, 15));
        fmask2 = 2'($urandom_range(0, 3));
      end
      sweep(id, rop, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
